// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks the ROM from the PC, assembles one- or two-byte
// instructions and hands them to decode over a valid/ready handshake.
module instr_fetch #(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [7:0]        imem_data,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [7:0]        instr_opcode,
   output logic [7:0]        instr_imm,
   output logic              instr_two_byte,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              halted
);

   typedef enum logic [1:0] {FETCH_OP, FETCH_IMM, PRESENT, HALTED} state_t;

   localparam logic [7:0] OP_HLT = 8'hFF;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] ipc_q, ipc_d;
   logic [7:0]        op_q, op_d;
   logic [7:0]        imm_q, imm_d;
   logic              two_q, two_d;
   logic              is_two;

   // Opcodes with bit 7 set carry an immediate/address byte, except HLT.
   assign is_two = imem_data[7] && (imem_data != OP_HLT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH_OP;
         pc_q    <= RESET_PC;
         ipc_q   <= '0;
         op_q    <= '0;
         imm_q   <= '0;
         two_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ipc_q   <= ipc_d;
         op_q    <= op_d;
         imm_q   <= imm_d;
         two_q   <= two_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ipc_d   = ipc_q;
      op_d    = op_q;
      imm_d   = imm_q;
      two_d   = two_q;

      case (state_q)
         FETCH_OP: begin
            op_d  = imem_data;
            ipc_d = pc_q;
            pc_d  = pc_q + 1'b1;
            two_d = is_two;
            if (is_two) begin
               state_d = FETCH_IMM;
            end else begin
               imm_d   = '0;
               state_d = PRESENT;
            end
         end
         FETCH_IMM: begin
            imm_d   = imem_data;
            pc_d    = pc_q + 1'b1;
            state_d = PRESENT;
         end
         PRESENT: begin
            if (instr_ready) begin
               state_d = (op_q == OP_HLT) ? HALTED : FETCH_OP;
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = FETCH_OP;
         end
      endcase

      // A redirect discards whatever was being assembled; instruction registers
      // keep their old contents since valid stays low until the new fetch ends.
      if (redirect_valid) begin
         state_d = FETCH_OP;
         pc_d    = redirect_pc;
         ipc_d   = ipc_q;
         op_d    = op_q;
         imm_d   = imm_q;
         two_d   = two_q;
      end
   end

   assign imem_addr      = pc_q;
   assign instr_valid    = (state_q == PRESENT);
   assign halted         = (state_q == HALTED);
   assign instr_opcode   = op_q;
   assign instr_imm      = imm_q;
   assign instr_two_byte = two_q;
   assign instr_pc       = ipc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: instruction-level reference model checked every cycle,
// plus directed programs with literal accepted-instruction streams.
module tb_instr_fetch;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] imem_addr, imem_data;
   logic       instr_valid, instr_ready = 1'b0;
   logic [7:0] instr_opcode, instr_imm, instr_pc;
   logic       instr_two_byte, halted;
   logic       redirect_valid = 1'b0;
   logic [7:0] redirect_pc = 8'h00;

   logic [7:0] mem [256];
   assign imem_data = mem[imem_addr];

   instr_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst(rst),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_opcode(instr_opcode), .instr_imm(instr_imm),
      .instr_two_byte(instr_two_byte), .instr_pc(instr_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halted(halted)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Instruction-level model: which instruction is in flight, how many fetch
   // cycles remain before it is presented, and where the next one starts.
   logic       model_on = 1'b0;
   logic [7:0] m_start, m_next, m_op, m_imm;
   logic       m_two, m_valid, m_halted;
   int         m_wait;

   task automatic begin_instr(input logic [7:0] a);
      logic [7:0] a1;
      a1       = a + 8'd1;
      m_start  = a;
      m_op     = mem[a];
      m_two    = m_op[7] && (m_op != 8'hFF);
      m_imm    = m_two ? mem[a1] : 8'h00;
      m_next   = m_two ? a + 8'd2 : a1;
      m_wait   = m_two ? 2 : 1;
      m_valid  = 1'b0;
      m_halted = 1'b0;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         model_on = 1'b1;
         begin_instr(8'h00);
      end else if (model_on) begin
         if (redirect_valid) begin
            begin_instr(redirect_pc);
         end else if (m_halted) begin
            m_halted = 1'b1;
         end else if (m_valid) begin
            if (instr_ready) begin
               if (m_op == 8'hFF) begin
                  m_valid  = 1'b0;
                  m_halted = 1'b1;
               end else begin
                  begin_instr(m_next);
               end
            end
         end else begin
            m_wait = m_wait - 1;
            if (m_wait == 0) m_valid = 1'b1;
         end
      end
   end

   logic [31:0] acc_q [$];
   logic [31:0] exp_q [$];

   function automatic logic [31:0] ent(input logic [7:0] pc, input logic [7:0] op,
                                       input logic [7:0] imm, input logic two);
      return {pc, op, imm, 7'd0, two};
   endfunction

   // Per-cycle comparison against the model, plus capture of accepted instructions.
   always @(negedge clk) begin
      logic [7:0] ea;
      if (model_on) begin
         if (m_halted || m_valid) ea = m_next;
         else if (m_two && m_wait == 1) ea = m_start + 8'd1;
         else ea = m_start;
         chk("cyc_imem_addr", {24'd0, imem_addr}, {24'd0, ea});
         chk("cyc_valid", {31'd0, instr_valid}, {31'd0, m_valid});
         chk("cyc_halted", {31'd0, halted}, {31'd0, m_halted});
         if (m_valid) begin
            chk("cyc_instr", ent(instr_pc, instr_opcode, instr_imm, instr_two_byte),
                ent(m_start, m_op, m_imm, m_two));
         end
      end
      if (instr_valid && instr_ready && !rst)
         acc_q.push_back(ent(instr_pc, instr_opcode, instr_imm, instr_two_byte));
   end

   task automatic load_prog();
      logic [7:0] p [9];
      p = '{8'h90, 8'h0A, 8'h94, 8'h0B, 8'h18, 8'h1A, 8'hD8, 8'h0D, 8'hFF};
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      for (int i = 0; i < 9; i++) mem[i] = p[i];
   endtask

   task automatic push_full_stream();
      exp_q.push_back(ent(8'h00, 8'h90, 8'h0A, 1'b1));
      exp_q.push_back(ent(8'h02, 8'h94, 8'h0B, 1'b1));
      exp_q.push_back(ent(8'h04, 8'h18, 8'h00, 1'b0));
      exp_q.push_back(ent(8'h05, 8'h1A, 8'h00, 1'b0));
      exp_q.push_back(ent(8'h06, 8'hD8, 8'h0D, 1'b1));
      exp_q.push_back(ent(8'h08, 8'hFF, 8'h00, 1'b0));
   endtask

   task automatic cmp_stream(input string name);
      chk({name, "_count"}, acc_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < acc_q.size()) chk({name, "_entry"}, acc_q[i], exp_q[i]);
      end
      acc_q.delete();
      exp_q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      @(posedge clk); #1;
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_addr", {24'd0, imem_addr}, 32'h00);
      chk("rst_fields", ent(instr_pc, instr_opcode, instr_imm, instr_two_byte), 32'd0);
      rst = 1'b0;
      acc_q.delete();
   endtask

   task automatic wait_halt(input string name);
      int n = 0;
      while (!halted && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, "_halt_reached"}, {31'd0, halted}, 32'd1);
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!instr_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, "_valid_reached"}, {31'd0, instr_valid}, 32'd1);
   endtask

   task automatic wait_addr(input string name, input logic [7:0] a);
      int n = 0;
      while (imem_addr != a && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, "_addr_reached"}, {24'd0, imem_addr}, {24'd0, a});
   endtask

   initial begin
      int hcyc;
      @(posedge clk); #1;

      // Straight-line program with ready held high.
      load_prog();
      instr_ready = 1'b1;
      do_reset();
      hcyc = 0;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         if (halted && hcyc == 0) hcyc = c;
      end
      chk("t1_halt_cycle", hcyc, 15);
      chk("t1_final_addr", {24'd0, imem_addr}, 32'h09);
      push_full_stream();
      cmp_stream("t1");

      // Backpressure on the first instruction.
      instr_ready = 1'b0;
      do_reset();
      wait_valid("t2");
      for (int i = 0; i < 4; i++) begin
         chk("t2_hold_instr", ent(instr_pc, instr_opcode, instr_imm, instr_two_byte),
             ent(8'h00, 8'h90, 8'h0A, 1'b1));
         chk("t2_hold_addr", {24'd0, imem_addr}, 32'h02);
         @(posedge clk); #1;
      end
      instr_ready = 1'b1;
      wait_halt("t2");
      push_full_stream();
      cmp_stream("t2");

      // Redirect to 0x06 while the immediate of the 0x02 instruction is fetched.
      do_reset();
      wait_addr("t3", 8'h03);
      redirect_valid = 1'b1;
      redirect_pc = 8'h06;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      wait_halt("t3");
      chk("t3_final_addr", {24'd0, imem_addr}, 32'h09);
      exp_q.push_back(ent(8'h00, 8'h90, 8'h0A, 1'b1));
      exp_q.push_back(ent(8'h06, 8'hD8, 8'h0D, 1'b1));
      exp_q.push_back(ent(8'h08, 8'hFF, 8'h00, 1'b0));
      cmp_stream("t3");

      // Reset while fetching an immediate byte.
      do_reset();
      wait_addr("t5a", 8'h01);
      do_reset();
      wait_halt("t5a");
      push_full_stream();
      cmp_stream("t5a");

      // Reset while backpressured in PRESENT.
      instr_ready = 1'b0;
      do_reset();
      wait_valid("t5b");
      do_reset();
      instr_ready = 1'b1;
      wait_halt("t5b");
      push_full_stream();
      cmp_stream("t5b");

      // Redirect out of HALTED to 0x04.
      redirect_valid = 1'b1;
      redirect_pc = 8'h04;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      chk("t6_halted_low", {31'd0, halted}, 32'd0);
      chk("t6_bubble", {31'd0, instr_valid}, 32'd0);
      @(posedge clk); #1;
      chk("t6_valid", {31'd0, instr_valid}, 32'd1);
      chk("t6_instr", ent(instr_pc, instr_opcode, instr_imm, instr_two_byte),
          ent(8'h04, 8'h18, 8'h00, 1'b0));
      wait_halt("t6");

      // Redirect in the same cycle as an accepted transfer.
      do_reset();
      wait_valid("t7");
      redirect_valid = 1'b1;
      redirect_pc = 8'h04;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      wait_halt("t7");
      exp_q.push_back(ent(8'h00, 8'h90, 8'h0A, 1'b1));
      exp_q.push_back(ent(8'h04, 8'h18, 8'h00, 1'b0));
      exp_q.push_back(ent(8'h05, 8'h1A, 8'h00, 1'b0));
      exp_q.push_back(ent(8'h06, 8'hD8, 8'h0D, 1'b1));
      exp_q.push_back(ent(8'h08, 8'hFF, 8'h00, 1'b0));
      cmp_stream("t7");

      // PC wrap between opcode and immediate.
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'hFF] = 8'h90;
      mem[8'h00] = 8'h0A;
      mem[8'h01] = 8'hFF;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      acc_q.delete();
      redirect_valid = 1'b1;
      redirect_pc = 8'hFF;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      chk("t4_fetch_addr", {24'd0, imem_addr}, 32'hFF);
      wait_halt("t4");
      chk("t4_final_addr", {24'd0, imem_addr}, 32'h02);
      exp_q.push_back(ent(8'hFF, 8'h90, 8'h0A, 1'b1));
      exp_q.push_back(ent(8'h01, 8'hFF, 8'h00, 1'b0));
      cmp_stream("t4");

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
